axi4_mem_bridge: RTL and testbench
==================================

# axi4_mem_bridge

AXI4 slave front-end that converts INCR write and read bursts into single-word accesses on the simple synchronous memory port (mem_en/mem_we/mem_addr/mem_wdata/mem_rdata) used by the memory block. It is the initiator on the memory port and the responder on AXI. It handles one transaction at a time and returns SLVERR for illegal bursts without touching memory.

## Interface
- DATA_WIDTH, 32: AXI and memory data width in bits.
- ADDR_WIDTH, 16: AXI byte-address width.
- MEMORY_DEPTH, 1024: memory depth in words. MW = $clog2(MEMORY_DEPTH).
- ACLK  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- AWADDR/ARADDR  in  ADDR_WIDTH  burst start byte address.
- AWLEN/ARLEN  in  8  beats minus 1.
- AWSIZE/ARSIZE  in  3  beat size.
- AWVALID/ARVALID  in  1. AWREADY/ARREADY  out  1.
- WDATA  in  DATA_WIDTH. WLAST  in  1. WVALID  in  1. WREADY  out  1.
- BRESP  out  2. BVALID  out  1. BREADY  in  1.
- RDATA  out  DATA_WIDTH. RRESP  out  2. RLAST  out  1. RVALID  out  1. RREADY  in  1.
- mem_en  out  1. mem_we  out  1. mem_addr  out  MW. mem_wdata  out  DATA_WIDTH.
- mem_rdata  in  DATA_WIDTH: valid in the cycle after a read access.

## Operation
- FSM states: IDLE, WR_DATA, WR_RESP, RD_ISSUE, RD_CAPT, RD_DATA.
- IDLE: AWREADY=1 when the write is granted; ARREADY=1 when the read is granted. At most one of them is 1 in any cycle.
- Accepting a request latches start word = AxADDR[MW+1:2], len, and the error flag. Address bits [1:0] are ignored.
- The error flag is set when AxSIZE != $clog2(DATA_WIDTH/8) or when start + len >= MEMORY_DEPTH.
- WR_DATA: WREADY=1.
  - Each W handshake drives mem_en=1, mem_we=1, mem_addr=current word, mem_wdata=WDATA combinationally in the same cycle. Both enables are gated to 0 when the error flag is set.
  - The word address and the beat counter increment on each handshake.
  - The beat at counter==len ends the burst; next state is WR_RESP.
  - WLAST is not used to end the burst. WLAST=1 on any beat other than the final one, or WLAST=0 on the final beat, sets the mismatch flag.
- WR_RESP: BVALID=1. BRESP=2'b10 if the error or mismatch flag is set, else 2'b00. On BREADY the FSM returns to IDLE.
- RD_ISSUE: mem_en=1, mem_we=0, mem_addr=current word. Enables are gated to 0 when the error flag is set. Next state is RD_CAPT.
- RD_CAPT: the RDATA register loads mem_rdata, or 0 when the error flag is set. Next state is RD_DATA.
- RD_DATA: RVALID=1. RRESP=2'b10 if the error flag is set, else 2'b00. RLAST=1 when counter==len.
  - On RREADY: return to IDLE if this was the last beat; otherwise increment the word and go to RD_ISSUE.
- RDATA, RRESP and RLAST hold stable while RVALID=1 and RREADY=0.
- mem_en=0 in every state and cycle not listed above.
- Arbitration: with the macro undefined, a write wins whenever AWVALID and ARVALID are both 1 in IDLE.

## Timing
- rst_n low at a clock edge: state becomes IDLE, all counters and flags clear, RDATA/BRESP/RRESP/RLAST become 0.
- While rst_n is low, every ready, valid and mem_en/mem_we output is forced to 0 combinationally. mem_addr and mem_wdata read 0.
- Reset mid-burst abandons the burst with no response. Memory contents are not affected.
- Write: an AW handshake in cycle t puts the FSM in WR_DATA at t+1. The earliest first memory write is t+1.
- Single-beat write: BVALID is earliest at t+2.
- Read: an AR handshake in cycle t gives RD_ISSUE at t+1, RD_CAPT at t+2, and the first RVALID at t+3.
- Read throughput: one beat per 3 cycles with RREADY held at 1.
- Back-to-back transactions: IDLE lasts at least 1 cycle between them.
- len=255 is legal when in range. The 9-bit beat counter must not wrap.

## Configuration
- AXI4_MEM_RR_ARB_EN defined: round-robin arbitration. A last-granted flag (reset value = read) gives the simultaneous tie to the opposite direction of the previous grant.
- Undefined: fixed write priority, as described in Operation.

## Test plan
- Single write: AWADDR=0x0010, AWLEN=0, WDATA=0xDEADBEEF, WLAST=1 -> one cycle of mem_en=1, mem_we=1, mem_addr=4, mem_wdata=0xDEADBEEF; then BRESP=00.
- INCR read: ARADDR=0x0010, ARLEN=3 over words 4..7 preloaded with 1..4 -> RDATA sequence 1,2,3,4; RLAST only on the 4th beat; first RVALID 3 cycles after the AR handshake.
- Out-of-range burst: AWADDR=0x0FFC, AWLEN=1 (word 1023+1) -> 2 beats accepted, mem_en stays 0, BRESP=10.
- WLAST error: AWLEN=2 with WLAST=1 on beat 0 -> 3 beats written, BRESP=10.
- Simultaneous AWVALID and ARVALID on two consecutive requests -> macro undefined: write, write. Macro defined: write, then read.
- rst_n=0 during beat 2 of an 8-beat read -> RVALID=0 on the next cycle; the next AR gets ARREADY and a fresh burst from beat 0.

Source files
------------

// File: rtl/axi4_mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_mem_bridge
//  Brief    : AXI4 slave that turns INCR write/read bursts into single-word
//             accesses on a simple synchronous memory port. It handles one
//             transaction at a time. Bursts with an illegal size or a range
//             past the end of memory get SLVERR and never touch memory.
//  Config   : AXI4_MEM_RR_ARB_EN - round-robin AW/AR arbitration when
//             defined. When it is undefined, writes win a simultaneous tie.
//  Revision : 1.0 - initial release
// ============================================================================
module axi4_mem_bridge #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int MEMORY_DEPTH = 1024,
    localparam int MW          = $clog2(MEMORY_DEPTH)
) (
    input  logic                  ACLK,
    input  logic                  rst_n,
    // write address channel
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic [7:0]            AWLEN,
    input  logic [2:0]            AWSIZE,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    // write data channel
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic                  WLAST,
    input  logic                  WVALID,
    output logic                  WREADY,
    // write response channel
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    // read address channel
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic [7:0]            ARLEN,
    input  logic [2:0]            ARSIZE,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    // read data channel
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [1:0]            RRESP,
    output logic                  RLAST,
    output logic                  RVALID,
    input  logic                  RREADY,
    // memory port
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [MW-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [2:0]    SIZE_FULL   = 3'($clog2(DATA_WIDTH / 8));
    localparam logic [1:0]    RESP_OKAY   = 2'b00;
    localparam logic [1:0]    RESP_SLVERR = 2'b10;
    localparam logic [MW-1:0] WORD_ONE    = MW'(1);
    localparam logic [8:0]    CNT_ONE     = 9'd1;
    localparam logic [31:0]   DEPTH_U     = 32'(MEMORY_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_DATA  = 3'd1,
        ST_WR_RESP  = 3'd2,
        ST_RD_ISSUE = 3'd3,
        ST_RD_CAPT  = 3'd4,
        ST_RD_DATA  = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [MW-1:0]         word_q,  word_d;
    logic [7:0]            len_q,   len_d;
    logic [8:0]            cnt_q,   cnt_d;     // 9 bits so len=255 never wraps
    logic                  err_q,   err_d;
    logic                  mis_q,   mis_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [MW-1:0] w_aw_start;
    logic [MW-1:0] w_ar_start;
    logic          w_aw_err;
    logic          w_ar_err;
    logic          w_wr_grant;
    logic          w_rd_grant;
    logic          w_last_beat;
    logic          unused_addr_bits;

    // Only the word-address bits select memory; byte-lane and high bits are don't-care.
    assign unused_addr_bits = ^{AWADDR, ARADDR};

    assign w_aw_start = AWADDR[MW+1:2];
    assign w_ar_start = ARADDR[MW+1:2];
    assign w_aw_err   = (AWSIZE != SIZE_FULL) || ((32'(w_aw_start) + 32'(AWLEN)) >= DEPTH_U);
    assign w_ar_err   = (ARSIZE != SIZE_FULL) || ((32'(w_ar_start) + 32'(ARLEN)) >= DEPTH_U);

    assign w_last_beat = (cnt_q == {1'b0, len_q});

`ifdef AXI4_MEM_RR_ARB_EN
    logic last_wr_q, last_wr_d;    // 1 = previous grant was a write

    // A tie goes to the direction that did not win last time.
    assign w_wr_grant = AWVALID && (!ARVALID || !last_wr_q);
    assign w_rd_grant = ARVALID && (!AWVALID ||  last_wr_q);

    // Remember the direction of the most recent grant; reset behaves as "read".
    always_ff @(posedge ACLK) begin
        if (!rst_n) begin
            last_wr_q <= 1'b0;
        end else begin
            last_wr_q <= last_wr_d;
        end
    end
`else
    assign w_wr_grant = AWVALID;
    assign w_rd_grant = ARVALID && !AWVALID;
`endif

    assign RDATA = rdata_q;

    // State and datapath registers.
    always_ff @(posedge ACLK) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic and all handshake / memory-port outputs.
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        mis_d     = mis_q;
        rdata_d   = rdata_q;
`ifdef AXI4_MEM_RR_ARB_EN
        last_wr_d = last_wr_q;
`endif
        AWREADY   = 1'b0;
        ARREADY   = 1'b0;
        WREADY    = 1'b0;
        BVALID    = 1'b0;
        BRESP     = RESP_OKAY;
        RVALID    = 1'b0;
        RRESP     = RESP_OKAY;
        RLAST     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = word_q;
        mem_wdata = WDATA;

        case (state_q)
            ST_IDLE: begin
                if (w_wr_grant) begin
                    AWREADY = 1'b1;
                    state_d = ST_WR_DATA;
                    word_d  = w_aw_start;
                    len_d   = AWLEN;
                    cnt_d   = '0;
                    err_d   = w_aw_err;
                    mis_d   = 1'b0;
`ifdef AXI4_MEM_RR_ARB_EN
                    last_wr_d = 1'b1;
`endif
                end else if (w_rd_grant) begin
                    ARREADY = 1'b1;
                    state_d = ST_RD_ISSUE;
                    word_d  = w_ar_start;
                    len_d   = ARLEN;
                    cnt_d   = '0;
                    err_d   = w_ar_err;
                    mis_d   = 1'b0;
`ifdef AXI4_MEM_RR_ARB_EN
                    last_wr_d = 1'b0;
`endif
                end
            end

            ST_WR_DATA: begin
                WREADY = 1'b1;
                if (WVALID) begin
                    // Beats of an illegal burst are consumed but never reach memory.
                    mem_en = !err_q;
                    mem_we = !err_q;
                    word_d = word_q + WORD_ONE;
                    cnt_d  = cnt_q + CNT_ONE;
                    // The beat count ends the burst; WLAST only has to agree with it.
                    if (WLAST != w_last_beat) begin
                        mis_d = 1'b1;
                    end
                    if (w_last_beat) begin
                        state_d = ST_WR_RESP;
                    end
                end
            end

            ST_WR_RESP: begin
                BVALID = 1'b1;
                BRESP  = (err_q || mis_q) ? RESP_SLVERR : RESP_OKAY;
                if (BREADY) begin
                    state_d = ST_IDLE;
                end
            end

            ST_RD_ISSUE: begin
                mem_en  = !err_q;
                state_d = ST_RD_CAPT;
            end

            ST_RD_CAPT: begin
                // Memory returns data one cycle after the access.
                rdata_d = err_q ? '0 : mem_rdata;
                state_d = ST_RD_DATA;
            end

            ST_RD_DATA: begin
                RVALID = 1'b1;
                RRESP  = err_q ? RESP_SLVERR : RESP_OKAY;
                RLAST  = w_last_beat;
                if (RREADY) begin
                    if (w_last_beat) begin
                        state_d = ST_IDLE;
                    end else begin
                        word_d  = word_q + WORD_ONE;
                        cnt_d   = cnt_q + CNT_ONE;
                        state_d = ST_RD_ISSUE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reset silences every handshake and the memory port immediately.
        if (!rst_n) begin
            AWREADY   = 1'b0;
            ARREADY   = 1'b0;
            WREADY    = 1'b0;
            BVALID    = 1'b0;
            RVALID    = 1'b0;
            mem_en    = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4_mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi4_mem_bridge
//  Brief    : Scoreboard bench for axi4_mem_bridge with a behavioural memory.
//             Compile with AXI4_MEM_RR_ARB_EN to match a round-robin build.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_mem_bridge;

    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int DEPTH = 1024;
    localparam int MW    = 10;

    logic          ACLK = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] AWADDR = '0, ARADDR = '0;
    logic [7:0]    AWLEN = '0, ARLEN = '0;
    logic [2:0]    AWSIZE = 3'd2, ARSIZE = 3'd2;
    logic          AWVALID = 1'b0, ARVALID = 1'b0, AWREADY, ARREADY;
    logic [DW-1:0] WDATA = '0;
    logic          WLAST = 1'b0, WVALID = 1'b0, WREADY;
    logic [1:0]    BRESP, RRESP;
    logic          BVALID, BREADY = 1'b0;
    logic [DW-1:0] RDATA;
    logic          RLAST, RVALID, RREADY = 1'b0;
    logic          mem_en, mem_we;
    logic [MW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 ACLK = ~ACLK;

    axi4_mem_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEMORY_DEPTH(DEPTH)) dut (
        .ACLK(ACLK), .rst_n(rst_n),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Behavioural synchronous memory: read data appears the cycle after the access.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge ACLK) begin
        if (mem_en && mem_we)  mem[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
    end

    typedef struct packed { logic we; logic [MW-1:0] addr; logic [DW-1:0] data; } acc_t;
    typedef struct packed { logic [DW-1:0] data; logic last; logic [1:0] resp; } rbeat_t;

    acc_t          acc_q[$];
    rbeat_t        rd_q[$];
    logic [1:0]    b_q[$];
    logic [DW-1:0] model [DEPTH];
    bit            last_wr = 1'b0;
    int            vec_cnt = 0;
    int            err_cnt = 0;
    int            cyc = 0;

    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit burst_err(input logic [AW-1:0] addr, input logic [7:0] len, input logic [2:0] size);
        return (size != 3'd2) || ((int'(addr[11:2]) + int'(len)) >= DEPTH);
    endfunction

    // Every memory access must match the next expected one.
    always @(negedge ACLK) begin
        acc_t e;
        if (rst_n && mem_en) begin
            if (acc_q.size() == 0) begin
                check_value("mem_unexpected", {mem_we, mem_addr}, 0);
            end else begin
                e = acc_q.pop_front();
                check_value("mem_access", {mem_we, mem_addr, (mem_we ? mem_wdata : 32'h0)},
                            {e.we, e.addr, e.data});
            end
        end
    end

    task automatic do_write(input logic [AW-1:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [DW-1:0] base, input int bad_wlast, input bit tie, input int exp_lat);
        bit err, got;
        int n, t0;
        logic [MW-1:0] w;
        logic [DW-1:0] d;
        err = burst_err(addr, len, size);
        b_q.push_back((err || bad_wlast >= 0) ? 2'b10 : 2'b00);
        @(posedge ACLK); #1;
        AWADDR = addr; AWLEN = len; AWSIZE = size; AWVALID = 1'b1;
        if (tie) begin ARADDR = 16'h0; ARLEN = 8'd0; ARSIZE = 3'd2; ARVALID = 1'b1; end
        n = 0; got = 1'b0; t0 = 0;
        while (!got && n < 64) begin
            @(negedge ACLK);
            if (AWREADY) begin got = 1'b1; t0 = cyc; check_value("aw_excl_ar", ARREADY, 0); end
            @(posedge ACLK); #1; n++;
        end
        AWVALID = 1'b0; ARVALID = 1'b0;
        if (!got) begin check_value("aw_timeout", 0, 1); return; end
        last_wr = 1'b1;
        w = addr[11:2];
        for (int b = 0; b <= int'(len); b++) begin
            d = base + DW'(b);
            WDATA = d; WLAST = (b == int'(len)) ^ (b == bad_wlast); WVALID = 1'b1;
            if (!err) begin acc_q.push_back(acc_t'({1'b1, w, d})); model[w] = d; end
            w = w + 10'd1;
            n = 0; got = 1'b0;
            while (!got && n < 64) begin
                @(negedge ACLK);
                got = WREADY;
                @(posedge ACLK); #1; n++;
            end
            if (!got) begin WVALID = 1'b0; check_value("w_timeout", 0, 1); return; end
        end
        WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
        n = 0; got = 1'b0;
        while (!got && n < 64) begin
            @(negedge ACLK);
            if (BVALID) begin
                got = 1'b1;
                if (exp_lat > 0) check_value("b_latency", cyc - t0, exp_lat);
                check_value("bresp", BRESP, b_q.pop_front());
            end
            @(posedge ACLK); #1; n++;
        end
        BREADY = 1'b0;
        if (!got) check_value("b_timeout", 0, 1);
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input bit tie, input bit stall, input int reset_at);
        bit err, got, first;
        int n, t0, beat;
        logic [MW-1:0] w;
        rbeat_t r;
        err = burst_err(addr, len, size);
        w = addr[11:2];
        for (int b = 0; b <= int'(len); b++) begin
            if (!err) acc_q.push_back(acc_t'({1'b0, w, 32'h0}));
            rd_q.push_back(rbeat_t'({(err ? 32'h0 : model[w]), (b == int'(len)), (err ? 2'b10 : 2'b00)}));
            w = w + 10'd1;
        end
        @(posedge ACLK); #1;
        ARADDR = addr; ARLEN = len; ARSIZE = size; ARVALID = 1'b1;
        if (tie) begin AWADDR = 16'h0; AWLEN = 8'd0; AWSIZE = 3'd2; AWVALID = 1'b1; end
        n = 0; got = 1'b0; t0 = 0;
        while (!got && n < 64) begin
            @(negedge ACLK);
            if (ARREADY) begin got = 1'b1; t0 = cyc; check_value("ar_excl_aw", AWREADY, 0); end
            @(posedge ACLK); #1; n++;
        end
        ARVALID = 1'b0; AWVALID = 1'b0;
        if (!got) begin check_value("ar_timeout", 0, 1); acc_q.delete(); rd_q.delete(); return; end
        last_wr = 1'b0;
        beat = 0; first = 1'b1; n = 0;
        while (beat <= int'(len) && n < 4000) begin
            RREADY = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (beat == reset_at) begin
                rst_n = 1'b0;
                @(negedge ACLK);
                check_value("rst_rvalid_comb", {RVALID, mem_en, ARREADY}, 0);
                @(posedge ACLK); #1;
                rst_n = 1'b1; RREADY = 1'b0; last_wr = 1'b0;
                acc_q.delete(); rd_q.delete();
                @(negedge ACLK);
                check_value("rst_next_cycle", {RVALID, RDATA, RLAST, RRESP}, 0);
                return;
            end
            @(negedge ACLK);
            if (RVALID) begin
                if (first) begin check_value("r_latency", cyc - t0, 3); first = 1'b0; end
                if (RREADY) begin
                    r = rd_q.pop_front();
                    check_value("rbeat", {RDATA, RLAST, RRESP}, r);
                    beat++;
                end else begin
                    check_value("r_stall_hold", {RDATA, RLAST, RRESP}, rd_q[0]);
                end
            end
            @(posedge ACLK); #1; n++;
        end
        RREADY = 1'b0;
        if (beat <= int'(len)) begin check_value("r_timeout", 0, 1); acc_q.delete(); rd_q.delete(); end
    endtask

    // A simultaneous request is won by the direction the arbitration rule predicts.
    task automatic tie_request(input logic [DW-1:0] base);
        bit exp_wr;
`ifdef AXI4_MEM_RR_ARB_EN
        exp_wr = !last_wr;
`else
        exp_wr = 1'b1;
`endif
        if (exp_wr) do_write(16'h0300, 8'd0, 3'd2, base, -1, 1'b1, 0);
        else        do_read(16'h0300, 8'd0, 3'd2, 1'b1, 1'b0, -1);
    endtask

    initial begin
        // Reset with every request asserted: all outputs must stay quiet.
        rst_n = 1'b0; AWVALID = 1'b1; ARVALID = 1'b1; WVALID = 1'b1; WDATA = '1; BREADY = 1'b1; RREADY = 1'b1;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        check_value("rst_outputs",
                    {AWREADY, ARREADY, WREADY, BVALID, RVALID, mem_en, mem_we, mem_addr, mem_wdata}, 0);
        check_value("rst_regs", {RDATA, BRESP, RRESP, RLAST}, 0);
        @(posedge ACLK); #1;
        AWVALID = 1'b0; ARVALID = 1'b0; WVALID = 1'b0; WDATA = '0; BREADY = 1'b0; RREADY = 1'b0;
        rst_n = 1'b1;
        @(negedge ACLK);
        check_value("idle_quiet", {AWREADY, ARREADY, WREADY, BVALID, RVALID, mem_en}, 0);

        do_write(16'h0010, 8'd0, 3'd2, 32'hDEADBEEF, -1, 1'b0, 2);   // single write, word 4
        do_write(16'h0010, 8'd3, 3'd2, 32'h1, -1, 1'b0, 0);          // words 4..7 = 1..4
        do_read (16'h0010, 8'd3, 3'd2, 1'b0, 1'b0, -1);              // INCR read 1,2,3,4
        do_write(16'h0FFC, 8'd1, 3'd2, 32'h55, -1, 1'b0, 0);         // out of range
        do_write(16'h0020, 8'd0, 3'd1, 32'h66, -1, 1'b0, 0);         // bad size
        do_write(16'h0040, 8'd2, 3'd2, 32'hA0, 0, 1'b0, 0);          // WLAST early
        do_read (16'h0040, 8'd2, 3'd2, 1'b0, 1'b1, -1);              // written anyway
        do_read (16'h0FF8, 8'd2, 3'd2, 1'b0, 1'b0, -1);              // read out of range
        do_read (16'h0FFC, 8'd0, 3'd2, 1'b0, 1'b0, -1);              // last word, legal
        do_write(16'h0C00, 8'd255, 3'd2, 32'h1000, -1, 1'b0, 0);     // len 255 ending at 1023
        do_read (16'h0C00, 8'd255, 3'd2, 1'b0, 1'b1, -1);
        do_write(16'h0200, 8'd7, 3'd2, 32'h500, -1, 1'b0, 0);
        do_read (16'h0200, 8'd7, 3'd2, 1'b0, 1'b0, 2);               // reset during beat 2
        do_read (16'h0200, 8'd1, 3'd2, 1'b0, 1'b0, -1);              // fresh burst from beat 0
        tie_request(32'h7000);
        tie_request(32'h7100);

        repeat (3) @(posedge ACLK);
        check_value("acc_q_drained", acc_q.size(), 0);
        check_value("rd_q_drained", rd_q.size(), 0);
        check_value("b_q_drained", b_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
